// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared arbitration types and the round-robin pick helper for FIFO-port schedulers.
// Purely declarative: no state, no latency, no flow control of its own.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int RR_MAX_N = 8;

  // First set bit of valid searching upward from last+1, modulo n (n <= RR_MAX_N).
  function automatic logic [2:0] rr_next(input logic [RR_MAX_N-1:0] valid,
                                         input logic [2:0]          last,
                                         input int                  n = RR_MAX_N);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= RR_MAX_N; k++) begin
      idx = (int'(last) + k) % n;
      if (k <= n && !found && valid[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_priority.sv
// Round-robin picker: rotate so last+1 is bit 0, priority-encode, rotate the index back.
// Combinational, zero latency; no flow control.
module rr_priority #(
  parameter int N = 4
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] last,
  output logic [$clog2(N)-1:0] pick,
  output logic                 any
);

  localparam int LW = $clog2(N);

  logic [N-1:0] w_rot;
  int           w_off;

  always_comb begin
    w_rot = '0;
    for (int j = 0; j < N; j++) begin
      w_rot[j] = valid[LW'((int'(last) + 1 + j) % N)];
    end
    w_off = 0;
    for (int j = N - 1; j >= 0; j--) begin
      if (w_rot[j]) w_off = j;
    end
  end

  assign pick = LW'((int'(last) + 1 + w_off) % N);
  assign any  = |valid;

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers in bursts of BURST_LEN.
// Grant 1 cycle after request; 1 word/cycle in burst; fifo_full stalls the owner without losing the grant.
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]      fifo_wdata,
  output logic                       fifo_write,
  input  logic                       fifo_full,
  output logic [$clog2(NREQ)-1:0]    grant_id,
  output logic                       busy
);

  localparam int GW = $clog2(NREQ);
  localparam int BW = $clog2(BURST_LEN + 1);

  arb_state_t      r_state, w_state_nxt;
  logic [GW-1:0]   r_grant, w_grant_nxt;
  logic [GW-1:0]   r_last,  w_last_nxt;
  logic [BW-1:0]   r_beat,  w_beat_nxt;

  logic [GW-1:0]   w_pick;
  logic            w_any;
  logic            w_own_vld;
  logic            w_xfer;
  logic            w_last_beat;

  rr_priority #(.N(NREQ)) u_rr (
    .valid (req_valid),
    .last  (r_last),
    .pick  (w_pick),
    .any   (w_any)
  );

  assign w_own_vld   = req_valid[r_grant];
  assign w_xfer      = (r_state == BURST) & w_own_vld & ~fifo_full;
  assign w_last_beat = (r_beat == BW'(BURST_LEN - 1));
  assign fifo_wdata  = req_data[r_grant*DATA_WIDTH +: DATA_WIDTH];
  assign grant_id    = r_grant;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= GW'(NREQ - 1);
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_beat_nxt  = r_beat;
    busy        = 1'b0;
    req_ready   = '0;
    fifo_write  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = BURST;
          w_grant_nxt = w_pick;
          w_last_nxt  = w_pick;
          w_beat_nxt  = '0;
        end
      end
      BURST: begin
        busy               = 1'b1;
        req_ready[r_grant] = ~fifo_full;
        fifo_write         = w_xfer;
        if (w_xfer) w_beat_nxt = r_beat + 1'b1;
        // A full FIFO holds the grant: neither completion nor yield can fire while stalled.
        if ((w_xfer & w_last_beat) | (~w_own_vld & ~fifo_full)) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Scoreboard bench for fifo_rr_arbiter: producer queues feed the DUT, a negedge monitor checks
// every cycle against a round-robin reference model and pops expected words on each FIFO write.
module tb_fifo_rr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int BL   = 4;
  localparam int GW   = 2;

  logic                 clk = 1'b0;
  logic                 nrst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic [DW-1:0]        fifo_wdata;
  logic                 fifo_write;
  logic                 fifo_full;
  logic [GW-1:0]        grant_id;
  logic                 busy;

  fifo_rr_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_wdata (fifo_wdata),
    .fifo_write (fifo_write),
    .fifo_full  (fifo_full),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0]   prod_q [NREQ][$];
  logic [DW-1:0]   exp_q  [NREQ][$];
  logic [NREQ-1:0] en;
  logic [NREQ-1:0] hs;
  int              hs_cnt [NREQ];
  int              log_g [$];
  int              log_n [$];
  logic            prev_busy;

  logic            m_busy;
  int              m_owner;
  int              m_last;
  int              m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rr_model(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [NREQ-1:0] e_rdy;
    logic            e_wr;
    int              p;
    if (!nrst) begin
      m_busy    = 1'b0;
      m_last    = NREQ - 1;
      m_owner   = 0;
      m_cnt     = 0;
      hs        = '0;
      prev_busy = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_write", fifo_write, 0);
      chk("rst_ready", req_ready, 0);
    end else begin
      hs = req_valid & req_ready;
      if (busy && !prev_busy) begin
        log_g.push_back(grant_id);
        log_n.push_back(0);
      end
      prev_busy = busy;
      if (fifo_write && log_n.size() > 0) log_n[log_n.size()-1]++;
      if (fifo_write) begin
        if (exp_q[grant_id].size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL wdata: write of 0x%0h from lane %0d with nothing expected at %0t", fifo_wdata, grant_id, $time);
        end else begin
          chk("wdata", fifo_wdata, exp_q[grant_id].pop_front());
        end
      end
      if (!m_busy) begin
        chk("idle_busy", busy, 0);
        chk("idle_write", fifo_write, 0);
        chk("idle_ready", req_ready, 0);
        p = rr_model(req_valid, m_last);
        if (p >= 0) begin
          m_busy  = 1'b1;
          m_owner = p;
          m_last  = p;
          m_cnt   = 0;
        end
      end else begin
        e_rdy = '0;
        if (!fifo_full) e_rdy[m_owner] = 1'b1;
        e_wr = req_valid[m_owner] && !fifo_full;
        chk("burst_busy", busy, 1);
        chk("burst_grant", grant_id, m_owner);
        chk("burst_ready", req_ready, e_rdy);
        chk("burst_write", fifo_write, e_wr);
        if (e_wr) begin
          m_cnt++;
          if (m_cnt == BL) m_busy = 1'b0;
        end else if (!req_valid[m_owner] && !fifo_full) begin
          m_busy = 1'b0;
        end
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = en[i] && (prod_q[i].size() > 0);
      req_data[i*DW +: DW]  = (prod_q[i].size() > 0) ? prod_q[i][0] : '0;
    end
  endtask

  task automatic add_word(input int i, input logic [DW-1:0] w);
    prod_q[i].push_back(w);
    exp_q[i].push_back(w);
  endtask

  task automatic step();
    logic [DW-1:0] t;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (hs[i] && prod_q[i].size() > 0) begin
        t = prod_q[i].pop_front();
        hs_cnt[i]++;
      end
    end
    drive();
  endtask

  task automatic check_log(input string nm, input int s, input int n, input int eg[6], input int ec[6]);
    chk({nm, "_nbursts"}, log_g.size() - s, n);
    for (int k = 0; k < n; k++) begin
      if (s + k < log_g.size()) begin
        chk({nm, "_grant"}, log_g[s+k], eg[k]);
        chk({nm, "_count"}, log_n[s+k], ec[k]);
      end
    end
  endtask

  task automatic drained(input string nm);
    int tot;
    tot = 0;
    for (int i = 0; i < NREQ; i++) tot += exp_q[i].size();
    chk(nm, tot, 0);
  endtask

  initial begin
    int   s;
    int   base;
    logic flag;
    int   eg [6];
    int   ec [6];

    nrst      = 1'b1;
    en        = '1;
    fifo_full = 1'b0;
    req_valid = '0;
    req_data  = '0;
    hs        = '0;
    for (int i = 0; i < NREQ; i++) hs_cnt[i] = 0;
    #2 nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    chk("reset_busy", busy, 0);
    chk("reset_grant", grant_id, 0);
    chk("reset_write", fifo_write, 0);
    chk("reset_ready", req_ready, 0);

    // No requests: stays idle
    repeat (10) step();
    chk("idle_grant_id", grant_id, 0);

    // All four contend from reset: 0,1,2,3,0 in full bursts
    s = log_g.size();
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < ((i == 0) ? 8 : 4); k++) add_word(i, DW'(8'h40 + i*16 + k));
    drive();
    repeat (30) step();
    eg = '{0, 1, 2, 3, 0, 0};
    ec = '{4, 4, 4, 4, 4, 0};
    check_log("contend", s, 5, eg, ec);
    drained("contend_drain");

    // Single requester 2 streams 0x10..0x19
    s = log_g.size();
    for (int k = 0; k < 10; k++) add_word(2, DW'(8'h10 + k));
    drive();
    repeat (20) step();
    eg = '{2, 2, 2, 0, 0, 0};
    ec = '{4, 4, 2, 0, 0, 0};
    check_log("stream", s, 3, eg, ec);
    drained("stream_drain");

    // Requester 1 stalled by full after its 2nd word
    s    = log_g.size();
    base = hs_cnt[1];
    flag = 1'b0;
    for (int k = 0; k < 4; k++) add_word(1, DW'(8'hA0 + k));
    drive();
    for (int c = 0; c < 30; c++) begin
      step();
      if (!flag && hs_cnt[1] - base == 2) begin
        flag      = 1'b1;
        fifo_full = 1'b1;
        repeat (5) step();
        fifo_full = 1'b0;
      end
    end
    chk("stall_reached", flag, 1);
    eg = '{1, 0, 0, 0, 0, 0};
    ec = '{4, 0, 0, 0, 0, 0};
    check_log("stall", s, 1, eg, ec);
    drained("stall_drain");

    // Requester 3 yields after one word while 0 waits
    s = log_g.size();
    add_word(2, 8'h33);
    drive();
    repeat (6) step();
    base = hs_cnt[3];
    flag = 1'b0;
    for (int k = 0; k < 3; k++) add_word(3, DW'(8'hC0 + k));
    add_word(0, 8'h01);
    add_word(0, 8'h02);
    drive();
    for (int c = 0; c < 40; c++) begin
      step();
      if (!flag && hs_cnt[3] - base == 1) begin
        flag  = 1'b1;
        en[3] = 1'b0;
        drive();
      end
      if (flag && !en[3] && prod_q[0].size() == 0) begin
        en[3] = 1'b1;
        drive();
      end
    end
    eg = '{2, 3, 0, 3, 0, 0};
    ec = '{1, 1, 2, 2, 0, 0};
    check_log("yield", s, 4, eg, ec);
    chk("yield_r3_words", hs_cnt[3] - base, 3);
    drained("yield_drain");

    // Reset in the middle of a burst on requester 2
    base = hs_cnt[2];
    for (int k = 0; k < 6; k++) add_word(2, DW'(8'h70 + k));
    drive();
    for (int c = 0; c < 20; c++) begin
      step();
      if (hs_cnt[2] - base >= 2) break;
    end
    chk("midreset_started", (hs_cnt[2] - base >= 2), 1);
    #2 nrst = 1'b0;
    #1;
    chk("midreset_busy", busy, 0);
    chk("midreset_write", fifo_write, 0);
    chk("midreset_ready", req_ready, 0);
    for (int i = 0; i < NREQ; i++) begin
      prod_q[i].delete();
      exp_q[i].delete();
    end
    drive();
    repeat (2) step();
    nrst = 1'b1;
    s = log_g.size();
    for (int i = 0; i < NREQ; i++) begin
      add_word(i, DW'(8'h80 + i*16));
      add_word(i, DW'(8'h81 + i*16));
    end
    drive();
    repeat (25) step();
    eg = '{0, 1, 2, 3, 0, 0};
    ec = '{2, 2, 2, 2, 0, 0};
    check_log("after_reset", s, 4, eg, ec);
    drained("after_reset_drain");

    // Random traffic, random full, random yields
    for (int c = 0; c < 3000; c++) begin
      step();
      fifo_full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 19) == 0) en[i] = ~en[i];
      if ($urandom_range(0, 2) == 0) begin
        int r;
        r = $urandom_range(0, NREQ - 1);
        if (prod_q[r].size() < 6) add_word(r, DW'($urandom));
      end
      drive();
    end
    en        = '1;
    fifo_full = 1'b0;
    drive();
    repeat (200) step();
    drained("random_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
